// File: rtl/rr_arb_pkg.sv
// Shared encodings for the round-robin / fixed-priority FIFO arbiter.
package rr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic MODE_RR   = 1'b0;
    localparam logic MODE_PRIO = 1'b1;

endpackage

// File: rtl/rr_priority_pick.sv
// Circular find-first over the eligible set; fixed-priority mode always searches from channel 0.
module rr_priority_pick
    import rr_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [SEL_W-1:0]  start,
    input  logic              mode,
    output logic [SEL_W-1:0]  winner,
    output logic              any_valid
);

    int base;
    int idx;

    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        base      = (mode == MODE_PRIO) ? 0 : int'(start);
        for (int k = 0; k < NUM_CH; k++) begin
            idx = base + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!any_valid && eligible[idx]) begin
                winner    = SEL_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// FIFO read arbiter: registered one-hot pop, then a one-cycle-delayed mux select and valid.
module rr_arbiter_n
    import rr_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] request,
    input  logic [NUM_CH-1:0] chan_en,
    input  logic              mode,
    input  logic              pause,
    output logic [NUM_CH-1:0] pop,
    output logic [SEL_W-1:0]  port_sel,
    output logic              valid_out,
    output logic              idle
);

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   pop_q, pop_d;
    logic [SEL_W-1:0]    last_q, last_d;
    logic [SEL_W-1:0]    sel_p0_q, sel_p0_d;
    logic [SEL_W-1:0]    port_sel_q;
    logic                valid_q;
    logic                idle_q, idle_d;

    logic [NUM_CH-1:0]   eligible;
    logic [SEL_W-1:0]    start_idx;
    logic [SEL_W-1:0]    winner;
    logic                any_valid;

    // Masking the channel popped this cycle keeps a one-entry FIFO from being read twice.
    assign eligible  = request & chan_en & ~pop_q;
    assign start_idx = (last_q == SEL_W'(NUM_CH - 1)) ? '0 : last_q + 1'b1;

    rr_priority_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_pick (
        .eligible  (eligible),
        .start     (start_idx),
        .mode      (mode),
        .winner    (winner),
        .any_valid (any_valid)
    );

    always_comb begin
        state_d  = state_q;
        pop_d    = '0;
        last_d   = last_q;
        sel_p0_d = sel_p0_q;
        if (pause) begin
            state_d = HOLD;
        end else if (!any_valid) begin
            state_d = IDLE;
        end else begin
            state_d = ARB;
        end
        if (state_d == ARB) begin
            pop_d[winner] = 1'b1;
            last_d        = winner;
            sel_p0_d      = winner;
        end
        idle_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pop_q      <= '0;
            last_q     <= SEL_W'(NUM_CH - 1);
            sel_p0_q   <= '0;
            port_sel_q <= '0;
            valid_q    <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            pop_q      <= pop_d;
            last_q     <= last_d;
            sel_p0_q   <= sel_p0_d;
            // Select stage: the FIFO data for a pop arrives one cycle later.
            port_sel_q <= sel_p0_q;
            valid_q    <= |pop_q;
            idle_q     <= idle_d;
        end
    end

    assign pop       = pop_q;
    assign port_sel  = port_sel_q;
    assign valid_out = valid_q;
    assign idle      = idle_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: directed scenarios plus randomized traffic against a behavioural model.
module tb_rr_arbiter_n;

    localparam int N = 4;
    localparam int SW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  request;
    logic [N-1:0]  chan_en;
    logic          mode;
    logic          pause;
    logic [N-1:0]  pop;
    logic [SW-1:0] port_sel;
    logic          valid_out;
    logic          idle;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Behavioural model: what the outputs must be after the next rising edge.
    logic [N-1:0] m_pop;
    int           m_last;
    logic         m_vld;
    logic         m_idle;
    int           m_sel;
    int           m_pipe;

    always #5 clk = ~clk;

    rr_arbiter_n #(.NUM_CH(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .request   (request),
        .chan_en   (chan_en),
        .mode      (mode),
        .pause     (pause),
        .pop       (pop),
        .port_sel  (port_sel),
        .valid_out (valid_out),
        .idle      (idle)
    );

    task automatic model_edge();
        logic [N-1:0] elig;
        int w;
        elig = request & chan_en & ~m_pop;
        if (reset) begin
            m_pop  = '0;
            m_last = N - 1;
            m_vld  = 1'b0;
            m_sel  = 0;
            m_pipe = 0;
            m_idle = 1'b1;
        end else begin
            m_vld = |m_pop;
            m_sel = m_pipe;
            w = -1;
            if (!pause) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = mode ? k : (m_last + 1 + k) % N;
                    if (w < 0 && elig[c]) w = c;
                end
            end
            m_pop = '0;
            if (w >= 0) begin
                m_pop[w] = 1'b1;
                m_last   = w;
                m_pipe   = w;
            end
            m_idle = !pause && (elig == '0);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        request = '0;
        chan_en = '1;
        mode    = 1'b0;
        pause   = 1'b0;
        step();
        reset   = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        request = '1;
        chan_en = '1;
        mode    = 1'b0;
        pause   = 1'b0;
        step();
        step();
        cmp_cnt++; if (pop !== 4'b0000) begin err_cnt++; $display("FAIL reset_pop got=%b exp=0000", pop); end
        cmp_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
        cmp_cnt++; if (idle !== 1'b1) begin err_cnt++; $display("FAIL reset_idle got=%b exp=1", idle); end
        cmp_cnt++; if (port_sel !== 2'd0) begin err_cnt++; $display("FAIL reset_sel got=%0d exp=0", port_sel); end
        reset = 1'b0;
    endtask

    task automatic test_rotation();
        logic [N-1:0] exp_p [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int           exp_s [5] = '{0, 1, 2, 3, 0};
        do_reset();
        request = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i < 5) begin
                cmp_cnt++;
                if (pop !== exp_p[i]) begin err_cnt++; $display("FAIL rot_pop cyc=%0d got=%b exp=%b", i, pop, exp_p[i]); end
            end
            if (i >= 1) begin
                cmp_cnt++;
                if (valid_out !== 1'b1 || int'(port_sel) != exp_s[i-1]) begin
                    err_cnt++;
                    $display("FAIL rot_sel cyc=%0d got=%b/%0d exp=1/%0d", i, valid_out, port_sel, exp_s[i-1]);
                end
            end
        end
    endtask

    task automatic test_single();
        logic [N-1:0] ep;
        do_reset();
        request = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            step();
            ep = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            cmp_cnt++;
            if (pop !== ep) begin err_cnt++; $display("FAIL single_pop cyc=%0d got=%b exp=%b", i, pop, ep); end
            cmp_cnt++;
            if (valid_out !== (i % 2 == 1)) begin err_cnt++; $display("FAIL single_valid cyc=%0d got=%b exp=%b", i, valid_out, (i % 2 == 1)); end
            if (i % 2 == 1) begin
                cmp_cnt++;
                if (port_sel !== 2'd2) begin err_cnt++; $display("FAIL single_sel cyc=%0d got=%0d exp=2", i, port_sel); end
            end
        end
    endtask

    task automatic test_prio_then_rr();
        logic [N-1:0] ep;
        do_reset();
        request = 4'b1111;
        mode    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            ep = (i % 2 == 0) ? 4'b0001 : 4'b0010;
            cmp_cnt++;
            if (pop !== ep) begin err_cnt++; $display("FAIL prio_pop cyc=%0d got=%b exp=%b", i, pop, ep); end
        end
        // Last grant was channel 1, so round robin resumes at 2.
        mode = 1'b0;
        step();
        cmp_cnt++;
        if (pop !== 4'b0100) begin err_cnt++; $display("FAIL prio2rr_first got=%b exp=0100", pop); end
        for (int i = 0; i < 5; i++) begin
            step();
            cmp_cnt++;
            if (pop !== m_pop) begin err_cnt++; $display("FAIL prio2rr_pop cyc=%0d got=%b exp=%b", i, pop, m_pop); end
        end
    endtask

    task automatic test_pause();
        do_reset();
        request = 4'b1111;
        step(); step(); step();
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            cmp_cnt++;
            if (pop !== 4'b0000) begin err_cnt++; $display("FAIL pause_pop cyc=%0d got=%b exp=0000", i, pop); end
            if (i == 0) begin
                cmp_cnt++;
                if (valid_out !== 1'b1 || port_sel !== 2'd2) begin
                    err_cnt++;
                    $display("FAIL pause_drain got=%b/%0d exp=1/2", valid_out, port_sel);
                end
            end else begin
                cmp_cnt++;
                if (valid_out !== 1'b0 || idle !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL pause_hold cyc=%0d valid/idle got=%b/%b exp=0/0", i, valid_out, idle);
                end
            end
        end
        pause = 1'b0;
        step();
        cmp_cnt++;
        if (pop !== 4'b1000) begin err_cnt++; $display("FAIL pause_resume got=%b exp=1000", pop); end
        step();
        cmp_cnt++;
        if (pop !== 4'b0001) begin err_cnt++; $display("FAIL pause_resume2 got=%b exp=0001", pop); end
    endtask

    task automatic test_chan_en();
        logic [N-1:0] exp_p [8] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001,
                                    4'b0010, 4'b1000, 4'b0001, 4'b0010};
        do_reset();
        request = 4'b1111;
        chan_en = 4'b1011;
        for (int i = 0; i < 8; i++) begin
            step();
            cmp_cnt++;
            if (pop !== exp_p[i]) begin err_cnt++; $display("FAIL chen_pop cyc=%0d got=%b exp=%b", i, pop, exp_p[i]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        request = 4'b1111;
        step(); step(); step();
        cmp_cnt++;
        if (valid_out !== 1'b1) begin err_cnt++; $display("FAIL rstmid_pre_valid got=%b exp=1", valid_out); end
        reset = 1'b1;
        step();
        cmp_cnt++;
        if (pop !== 4'b0000 || valid_out !== 1'b0 || idle !== 1'b1) begin
            err_cnt++;
            $display("FAIL rstmid_out pop/valid/idle got=%b/%b/%b exp=0000/0/1", pop, valid_out, idle);
        end
        reset = 1'b0;
        step();
        cmp_cnt++;
        if (pop !== 4'b0001) begin err_cnt++; $display("FAIL rstmid_first got=%b exp=0001", pop); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset   = ($urandom_range(0, 59) == 0);
            request = N'($urandom);
            chan_en = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            pause   = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            step();
            cmp_cnt++;
            if (pop !== m_pop) begin err_cnt++; $display("FAIL rnd_pop cyc=%0d got=%b exp=%b", i, pop, m_pop); end
            cmp_cnt++;
            if (valid_out !== m_vld) begin err_cnt++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, valid_out, m_vld); end
            cmp_cnt++;
            if (idle !== m_idle) begin err_cnt++; $display("FAIL rnd_idle cyc=%0d got=%b exp=%b", i, idle, m_idle); end
            if (m_vld) begin
                cmp_cnt++;
                if (int'(port_sel) != m_sel) begin err_cnt++; $display("FAIL rnd_sel cyc=%0d got=%0d exp=%0d", i, port_sel, m_sel); end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        m_pop  = '0;
        m_last = N - 1;
        m_vld  = 1'b0;
        m_idle = 1'b1;
        m_sel  = 0;
        m_pipe = 0;
        test_reset();
        test_rotation();
        test_single();
        test_prio_then_rr();
        test_pause();
        test_chan_en();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_n.md
RR_ARBITER_N -- requirements
Module: rr_arbiter_n

Interface
REQ-001 Parameter NUM_CH, default 4, number of FIFO channels arbitrated; legal range 2..16.
REQ-002 Parameter SEL_W, default $clog2(NUM_CH), width of the channel-select outputs.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 request  input  NUM_CH  per-channel FIFO not-empty, one bit per channel.
REQ-006 chan_en  input  NUM_CH  per-channel enable; a disabled channel is never granted.
REQ-007 mode  input  1  0 = round robin, 1 = fixed priority (channel 0 highest).
REQ-008 pause  input  1  downstream almost-full; blocks new grants.
REQ-009 pop  output  NUM_CH  one-hot (or zero) registered FIFO read strobe.
REQ-010 port_sel  output  SEL_W  mux select, aligned with valid_out.
REQ-011 valid_out  output  1  mux output data valid.
REQ-012 idle  output  1  high while the FSM is in IDLE.

Function
REQ-013 Eligible set each cycle SHALL be request & chan_en & ~pop, so the channel popped in the current cycle is locked out for one cycle to prevent over-reading a one-entry FIFO.
REQ-014 The FSM SHALL have three states: IDLE (eligible set empty), ARB (granting), and HOLD (pause high).
REQ-015 Transitions SHALL be evaluated in this priority order: pause=1 goes to HOLD; otherwise an empty eligible set goes to IDLE; otherwise the FSM goes to ARB.
REQ-016 In ARB with mode=0, the winner SHALL be the first eligible channel found searching circularly from last_grant+1.
REQ-017 In ARB with mode=1, the winner SHALL be the lowest-index eligible channel.
REQ-018 Decision latency: eligibility sampled at edge t SHALL produce pop[winner]=1 during cycle t+1, with all other pop bits 0.
REQ-019 last_grant SHALL update only on an actual grant, and SHALL be updated in both modes.
REQ-020 A mode change SHALL take effect on the next decision; last_grant SHALL be preserved across the change.
REQ-021 port_sel and valid_out SHALL follow pop by one cycle (one-cycle FIFO read latency): valid_out=1 and port_sel=winner during cycle t+2.
REQ-022 pause=1 SHALL force pop=0 from the next cycle onward.
REQ-023 A pop already issued when pause rises SHALL still produce its valid_out, so the pipeline drains.
REQ-024 In HOLD or IDLE, pop SHALL be 0; valid_out SHALL fall one cycle after the last pop.
REQ-025 With a single eligible channel continuously requesting, pops SHALL alternate 1,0,1,0 (lockout).
REQ-026 With all channels requesting in mode=0, the throughput SHALL be one pop per cycle in rotation.
REQ-027 Deassertion of chan_en SHALL remove the channel from the next decision; an in-flight pop or valid_out SHALL complete.
REQ-028 last_grant SHALL wrap from NUM_CH-1 to 0.

Reset
REQ-029 While reset=1 at an edge, the block SHALL set pop=0, port_sel=0, valid_out=0, idle=1, FSM=IDLE, last_grant=NUM_CH-1 (first round-robin search starts at channel 0), and clear the select pipeline.
REQ-030 Reset asserted mid-operation SHALL discard in-flight pops and valids; all outputs SHALL be at reset values the cycle after the reset edge.
REQ-031 The first grant after reset release SHALL occur no earlier than one cycle after the first edge with reset=0.

Structure
REQ-032 A shared package rr_arb_pkg SHALL hold the FSM state encoding (IDLE, ARB, HOLD) and the MODE_RR/MODE_PRIO constants.
REQ-033 The circular find-first logic SHALL be a combinational sub-module rr_priority_pick, with inputs eligible, start index and mode, and outputs winner index and any_valid.
REQ-034 All outputs SHALL be driven directly from flops.

Verification (NUM_CH=4)
REQ-035 Scenario: request=1111, chan_en=1111, mode=0 -> pop sequence 0001, 0010, 0100, 1000, 0001; port_sel 0,1,2,3,0, lagging pop by one cycle.
REQ-036 Scenario: only request[2]=1 held -> pop 0100, 0000, 0100, 0000; valid_out pulses every other cycle with port_sel=2.
REQ-037 Scenario: request=1111, mode=1 -> the eligible set alternates around the locked-out channel; pop is 0001, then 0010, then 0001, ... (channels 2 and 3 starve); then switch to mode=0 -> rotation resumes from last_grant+1.
REQ-038 Scenario: pause pulsed high for 3 cycles during rotation -> pop=0 for those 3 cycles; the valid_out from the pre-pause pop still appears; rotation resumes at the next channel.
REQ-039 Scenario: chan_en=1011 with request=1111 -> channel 2 never popped; rotation is 0, 1, 3, 0.
REQ-040 Scenario: reset asserted while valid_out=1 -> the next cycle shows pop=0, valid_out=0, idle=1; after release the first grant goes to channel 0.
